// File: rtl/agnus_dma_pkg.sv
// agnus_dma_pkg: owner encoding, fixed-slot bounds and grant helper for the DMA slot arbiter
package agnus_dma_pkg;
  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] REF  = 4'd1;
  localparam logic [3:0] DSK  = 4'd2;
  localparam logic [3:0] AUD  = 4'd3;
  localparam logic [3:0] BPL  = 4'd4;
  localparam logic [3:0] SPR  = 4'd5;
  localparam logic [3:0] COP  = 4'd6;
  localparam logic [3:0] BLT  = 4'd7;
  localparam logic [3:0] CPU  = 4'd8;
  localparam logic [7:0] SLOT_REF_LO = 8'h01;
  localparam logic [7:0] SLOT_REF_HI = 8'h07;
  localparam logic [7:0] SLOT_DSK_LO = 8'h09;
  localparam logic [7:0] SLOT_DSK_HI = 8'h0D;
  localparam logic [7:0] SLOT_AUD_LO = 8'h0F;
  localparam logic [7:0] SLOT_AUD_HI = 8'h15;
  localparam logic [7:0] SLOT_SPR_LO = 8'h17;
  localparam logic [7:0] SLOT_SPR_HI = 8'h35;
  function automatic logic [7:0] onehot(input logic [3:0] o);
    return o == IDLE ? 8'd0 : 8'd1 << (o - 4'd1);
  endfunction
endpackage

// File: rtl/agnus_dma_slot_arbiter_if.sv
// agnus_dma_slot_arbiter_if: slot timing, DMA requests and grant outputs of the slot arbiter
interface agnus_dma_slot_arbiter_if;
  logic       CLK7_EN;
  logic       CCK;
  logic [8:0] hpos;
  logic       req_ref;
  logic       req_dsk;
  logic       req_aud;
  logic       req_bpl;
  logic       req_spr;
  logic       req_cop;
  logic       req_blt;
  logic       req_cpu;
  logic       bltpri;
  logic [7:0] gnt;
  logic [3:0] owner;
  logic       slot_start;
  modport master (
    output CLK7_EN, CCK, hpos, req_ref, req_dsk, req_aud, req_bpl, req_spr, req_cop, req_blt, req_cpu, bltpri,
    input  gnt, owner, slot_start
  );
  modport slave (
    input  CLK7_EN, CCK, hpos, req_ref, req_dsk, req_aud, req_bpl, req_spr, req_cop, req_blt, req_cpu, bltpri,
    output gnt, owner, slot_start
  );
endinterface

// File: rtl/agnus_dma_slot_decode.sv
// agnus_dma_slot_decode: maps the beam position to the fixed owner of the slot (odd slots only)
module agnus_dma_slot_decode
  import agnus_dma_pkg::*;
(
  input  logic [8:0] hpos,
  output logic [3:0] fixed
);
  logic [7:0] s;
  logic       unused_lsb;
  assign s = hpos[8:1];
  assign unused_lsb = hpos[0];
  always_comb
    fixed = !s[0] ? IDLE :
            (s >= SLOT_REF_LO && s <= SLOT_REF_HI) ? REF :
            (s >= SLOT_DSK_LO && s <= SLOT_DSK_HI) ? DSK :
            (s >= SLOT_AUD_LO && s <= SLOT_AUD_HI) ? AUD :
            (s >= SLOT_SPR_LO && s <= SLOT_SPR_HI) ? SPR : IDLE;
endmodule

// File: rtl/agnus_dma_slot_arbiter.sv
// agnus_dma_slot_arbiter: per-slot DMA grant, decided on CLK7_EN & CCK edges and held for the slot.
// Define AGNUS_DMA_BLIT_YIELD_EN to let a starved cpu take one slot from the blitter.
module agnus_dma_slot_arbiter
  import agnus_dma_pkg::*;
(
  input logic                           CLK28,
  input logic                           RST,
  agnus_dma_slot_arbiter_if.slave       bus
);
  logic [3:0] fixed;
  logic [3:0] nxt;
  logic [3:0] own_q;
  logic       dec;
  logic       cpu_first;
  agnus_dma_slot_decode u_decode (.hpos(bus.hpos), .fixed(fixed));
  assign dec = bus.CLK7_EN & bus.CCK;
`ifdef AGNUS_DMA_BLIT_YIELD_EN
  logic [1:0] cpu_wait;
  assign cpu_first = cpu_wait == 2'd3 && !bus.bltpri;
  always_ff @(posedge CLK28)
    if (RST) cpu_wait <= 2'd0;
    else if (dec)
      cpu_wait <= nxt == CPU ? 2'd0 :
                  (nxt == BLT && bus.req_cpu && cpu_wait != 2'd3) ? cpu_wait + 2'd1 : cpu_wait;
`else
  logic unused_bltpri;
  assign unused_bltpri = bus.bltpri;
  assign cpu_first = 1'b0;
`endif
  // fixed owners first, then bpl, sprites, copper on even slots, finally blitter/cpu
  always_comb
    nxt = fixed == REF ? REF :
          (fixed == DSK && bus.req_dsk) ? DSK :
          (fixed == AUD && bus.req_aud) ? AUD :
          bus.req_bpl ? BPL :
          (fixed == SPR && bus.req_spr) ? SPR :
          (bus.req_cop && !bus.hpos[1]) ? COP :
          (bus.req_cpu && (!bus.req_blt || cpu_first)) ? CPU :
          bus.req_blt ? BLT : IDLE;
  always_ff @(posedge CLK28)
    if (RST) own_q <= IDLE;
    else if (dec) own_q <= nxt;
  assign bus.owner = own_q;
  assign bus.gnt = onehot(own_q);
  assign bus.slot_start = dec & !RST;
endmodule

// File: doc/agnus_dma_slot_arbiter.md
AGNUS_DMA_SLOT_ARBITER -- requirements
Module: agnus_dma_slot_arbiter

Interface
REQ-001 SHALL have the input CLK28, 1 bit: system clock (28 MHz).
REQ-002 SHALL have the input RST, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have the input CLK7_EN, 1 bit: 7 MHz enable, one CLK28 cycle in four.
REQ-004 SHALL have the input CCK, 1 bit: colour clock; a slot starts on a CLK7_EN edge with CCK=1.
REQ-005 SHALL have the input hpos, 9 bits: beam position; hpos[8:1] is the slot number.
REQ-006 SHALL have the inputs req_ref, req_dsk, req_aud, req_bpl, req_spr, req_cop, req_blt and req_cpu, 1 bit each: requests, level-sensitive.
REQ-007 SHALL have the input bltpri, 1 bit: blitter-nasty flag.
REQ-008 SHALL have the output gnt, 8 bits: one-hot grant, bit order ref,dsk,aud,bpl,spr,cop,blt,cpu (bit0=ref).
REQ-009 SHALL have the output owner, 4 bits: encoded owner; 0 means idle, 1..8 follow the gnt bit order.
REQ-010 SHALL have the output slot_start, 1 bit: a one-CLK28 pulse on each slot decision edge.

Function
REQ-011 SHALL evaluate arbitration only on CLK28 edges with CLK7_EN=1 and CCK=1; gnt and owner are registered and held constant until the next such edge.
REQ-012 SHALL fix the slot owners on odd slots only:
- 0x01–0x07: ref.
- 0x09–0x0D: dsk.
- 0x0F–0x15: aud.
- 0x17–0x35: spr.
- All other slots: none.
REQ-013 SHALL grant, per slot, the first match in this order:
- ref, if the slot is a ref slot (regardless of req_ref).
- dsk or aud, if the slot is theirs and the request is high.
- bpl, if req_bpl.
- spr, if the slot is theirs and req_spr.
- cop, if req_cop and the slot is even.
- the blt/cpu resolution.
- idle.
REQ-014 SHALL grant a fixed slot whose owner is not requesting to the next eligible requester; the slot shall not go idle while any eligible request is high.
REQ-015 SHALL resolve blt/cpu as follows:
- Only one requesting: grant it.
- Both requesting: grant blt, except as REQ-016 allows.
REQ-016 SHALL keep a 2-bit starvation counter cpu_wait, used only when AGNUS_DMA_BLIT_YIELD_EN is defined:
- Increment, saturating at 3, on each decision where req_cpu=1 and blt was granted.
- Clear on any decision granting cpu.
- Hold otherwise.
- When cpu_wait=3, bltpri=0 and req_cpu=1, grant cpu over blt.
REQ-017 SHALL NOT revoke a grant mid-slot when its request drops; the new request state applies at the next decision edge.
REQ-018 SHALL keep owner consistent with gnt in the same cycle; gnt shall never have more than one bit set.
REQ-019 SHALL assert slot_start combinationally, equal to (CLK7_EN & CCK) gated by !RST.
REQ-020 SHALL decode hpos values whose slot number exceeds 0x35 as unowned (no fixed owner).

Reset
REQ-021 SHALL drive, on the first CLK28 edge with RST=1: gnt=0, owner=0, cpu_wait=0; RST overrides a decision edge in the same cycle.
REQ-022 SHALL hold all outputs at reset values while RST=1; the first grant is produced at the first decision edge after RST falls.

Configuration
REQ-023 SHALL, when AGNUS_DMA_BLIT_YIELD_EN is defined, include the cpu_wait counter and the REQ-016 yield.
REQ-024 SHALL, when AGNUS_DMA_BLIT_YIELD_EN is undefined, omit cpu_wait entirely, so that blt always beats cpu regardless of bltpri.

Structure
REQ-025 SHALL place the following in the shared package agnus_dma_pkg:
- The owner encoding constants (IDLE=0 .. CPU=8).
- The fixed-slot boundary constants (0x01, 0x07, 0x09, 0x0D, 0x0F, 0x15, 0x17, 0x35).
REQ-026 SHALL implement the hpos-to-fixed-owner mapping in one combinational sub-module, agnus_dma_slot_decode, instantiated once.

Verification
REQ-027 SHALL have a bench verify: hpos[8:1]=0x03, all requests high -> gnt=0x01, owner=1.
REQ-028 SHALL have a bench verify: slot 0x19 with req_spr=1 and req_bpl=1 -> gnt=0x08 (bpl); then with req_bpl=0 -> gnt=0x10 (spr).
REQ-029 SHALL have a bench verify: slot 0x40 (even) with req_cop=1 and req_blt=1 -> cop; slot 0x41 (odd) with the same requests -> blt.
REQ-030 SHALL have a bench verify, with YIELD_EN defined, bltpri=0, and req_blt and req_cpu held high over free slots -> grants blt,blt,blt,cpu,blt,... repeating; with bltpri=1 -> blt every slot.
REQ-031 SHALL have a bench verify: req_dsk dropped mid-slot 0x09 -> gnt stays 0x02 until the next decision edge.
REQ-032 SHALL have a bench verify: RST asserted mid-slot -> gnt=0 and owner=0 on the next CLK28 edge, with cpu_wait cleared.
